pacman_motion_ctrl: RTL and testbench

//  Sequences the player sprite position that the VGA overlay draws. Takes the held PS/2 scan code and the

---
 rtl/pacman_pkg.sv | 43 ++++
 rtl/pacman_frame_tick_gen.sv | 34 +++
 rtl/pacman_motion_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pacman_motion_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared constants for the player sprite: screen and sprite dimensions,
// direction encodings, PS/2 key codes and the key decoder.
package pacman_pkg;

   localparam int unsigned DEF_SCREEN_W    = 640;
   localparam int unsigned DEF_SCREEN_H    = 480;
   localparam int unsigned DEF_SPRITE_W    = 32;
   localparam int unsigned DEF_SPRITE_H    = 32;
   localparam int unsigned DEF_STEP_PX     = 2;
   localparam int unsigned DEF_STEP_FRAMES = 2;
   localparam int unsigned DEF_START_X     = 304;
   localparam int unsigned DEF_START_Y     = 224;

   localparam logic [1:0] DIR_RIGHT = 2'b00;
   localparam logic [1:0] DIR_UP    = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_DOWN  = 2'b11;

   localparam logic [7:0] KEY_RIGHT = 8'h74;
   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_DOWN  = 8'h72;

   typedef struct packed {
      logic       valid;
      logic [1:0] dir;
   } dir_req_t;

   function automatic dir_req_t decode_key(input logic [7:0] code);
      dir_req_t r;
      r.valid = 1'b1;
      r.dir   = DIR_RIGHT;
      case (code)
         KEY_RIGHT: r.dir = DIR_RIGHT;
         KEY_UP:    r.dir = DIR_UP;
         KEY_LEFT:  r.dir = DIR_LEFT;
         KEY_DOWN:  r.dir = DIR_DOWN;
         default:   r.valid = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/pacman_frame_tick_gen.sv
// Step timer: detects the falling edge of vertical sync and divides the
// frame rate by STEP_FRAMES, producing a single-cycle tick on each wrap.
module frame_tick_gen
   import pacman_pkg::*;
#(
   parameter int unsigned STEP_FRAMES = DEF_STEP_FRAMES
) (
   input  logic vga_clk,
   input  logic reset,
   input  logic vs_n,
   output logic tick
);

   logic       vs_n_q;
   logic       vs_fall;
   logic [3:0] frame_cnt;

   assign vs_fall = vs_n_q & ~vs_n;
   assign tick    = vs_fall && (frame_cnt == 4'(STEP_FRAMES - 1));

   // previous vs_n sample and frame divider, advanced once per frame
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         vs_n_q    <= 1'b1;
         frame_cnt <= '0;
      end else begin
         vs_n_q <= vs_n;
         if (vs_fall) begin
            frame_cnt <= tick ? '0 : frame_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/pacman_motion_ctrl.sv
// Player sprite motion sequencer: latches the requested direction, tries
// the queued turn then the current heading against the maze-wall lookup,
// and commits the new position only during vertical sync.
module pacman_motion_ctrl
   import pacman_pkg::*;
#(
   parameter int unsigned SCREEN_W    = DEF_SCREEN_W,
   parameter int unsigned SCREEN_H    = DEF_SCREEN_H,
   parameter int unsigned SPRITE_W    = DEF_SPRITE_W,
   parameter int unsigned SPRITE_H    = DEF_SPRITE_H,
   parameter int unsigned STEP_PX     = DEF_STEP_PX,
   parameter int unsigned STEP_FRAMES = DEF_STEP_FRAMES,
   parameter int unsigned START_X     = DEF_START_X,
   parameter int unsigned START_Y     = DEF_START_Y
) (
   input  logic       vga_clk,
   input  logic       reset,
   input  logic       vs_n,
   input  logic [7:0] key_code,
   input  logic       wall_ack,
   input  logic       wall_hit,
   output logic       wall_req,
   output logic [9:0] cand_x,
   output logic [8:0] cand_y,
   output logic [9:0] sprite_x,
   output logic [8:0] sprite_y,
   output logic [1:0] dir,
   output logic       moving,
   output logic       step_done
);

   localparam logic [10:0] XMAX_11 = 11'(SCREEN_W - SPRITE_W);
   localparam logic [9:0]  XMAX_10 = 10'(SCREEN_W - SPRITE_W);
   localparam logic [9:0]  YMAX_10 = 10'(SCREEN_H - SPRITE_H);
   localparam logic [10:0] STEP_11 = 11'(STEP_PX);
   localparam logic [9:0]  STEP_10 = 10'(STEP_PX);
   localparam logic [8:0]  STEP_9  = 9'(STEP_PX);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_TRY_Q  = 3'd1;
   localparam logic [2:0] ST_WAIT_Q = 3'd2;
   localparam logic [2:0] ST_TRY_C  = 3'd3;
   localparam logic [2:0] ST_WAIT_C = 3'd4;
   localparam logic [2:0] ST_COMMIT = 3'd5;
   localparam logic [2:0] ST_HOLD   = 3'd6;

   logic [2:0]  state;
   logic        tick;
   dir_req_t    key_req;
   dir_req_t    queued;
   logic [1:0]  turn_dir;
   logic [1:0]  try_dir;
   logic [10:0] x_sum;
   logic [9:0]  y_sum;
   logic [9:0]  nx;
   logic [8:0]  ny;
   logic        blocked;

   frame_tick_gen #(
      .STEP_FRAMES(STEP_FRAMES)
   ) u_frame_tick_gen (
      .vga_clk(vga_clk),
      .reset  (reset),
      .vs_n   (vs_n),
      .tick   (tick)
   );

   assign key_req = decode_key(key_code);
   assign try_dir = (state == ST_TRY_Q) ? queued.dir : dir;
   assign x_sum   = {1'b0, sprite_x} + STEP_11;
   assign y_sum   = {1'b0, sprite_y} + STEP_10;

   // next position in try_dir: horizontal tunnel wrap, vertical edges block
   always_comb begin
      nx      = sprite_x;
      ny      = sprite_y;
      blocked = 1'b0;
      case (try_dir)
         DIR_RIGHT: nx = (x_sum > XMAX_11) ? '0 : x_sum[9:0];
         DIR_LEFT:  nx = (sprite_x < STEP_10) ? XMAX_10 : sprite_x - STEP_10;
         DIR_UP: begin
            if (sprite_y < STEP_9) blocked = 1'b1;
            else                   ny = sprite_y - STEP_9;
         end
         DIR_DOWN: begin
            if (y_sum > YMAX_10) blocked = 1'b1;
            else                 ny = y_sum[8:0];
         end
      endcase
   end

   // key latch, step sequencer, wall handshake and position commit
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         queued    <= '0;
         turn_dir  <= DIR_LEFT;
         dir       <= DIR_LEFT;
         sprite_x  <= 10'(START_X);
         sprite_y  <= 9'(START_Y);
         moving    <= 1'b0;
         wall_req  <= 1'b0;
         cand_x    <= '0;
         cand_y    <= '0;
         step_done <= 1'b0;
      end else begin
         step_done <= 1'b0;
         if (key_req.valid) queued <= key_req;
         case (state)
            ST_IDLE: begin
               if (tick) begin
                  state <= (queued.valid && (queued.dir != dir)) ? ST_TRY_Q : ST_TRY_C;
               end
            end
            ST_TRY_Q: begin
               // turn_dir pins the direction under test; queued may change mid-handshake
               turn_dir <= queued.dir;
               if (blocked) begin
                  state <= ST_TRY_C;
               end else begin
                  cand_x   <= nx;
                  cand_y   <= ny;
                  wall_req <= 1'b1;
                  state    <= ST_WAIT_Q;
               end
            end
            ST_WAIT_Q: begin
               if (wall_ack) begin
                  wall_req <= 1'b0;
                  if (!wall_hit) begin
                     dir          <= turn_dir;
                     queued.valid <= 1'b0;
                     state        <= ST_COMMIT;
                  end else begin
                     state <= ST_TRY_C;
                  end
               end
            end
            ST_TRY_C: begin
               if (blocked) begin
                  state <= ST_HOLD;
               end else begin
                  cand_x   <= nx;
                  cand_y   <= ny;
                  wall_req <= 1'b1;
                  state    <= ST_WAIT_C;
               end
            end
            ST_WAIT_C: begin
               if (wall_ack) begin
                  wall_req <= 1'b0;
                  state    <= wall_hit ? ST_HOLD : ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               if (!vs_n) begin
                  sprite_x  <= cand_x;
                  sprite_y  <= cand_y;
                  moving    <= 1'b1;
                  step_done <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            ST_HOLD: begin
               moving    <= 1'b0;
               step_done <= 1'b1;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// Bench for pacman_motion_ctrl: a wall-lookup responder with configurable
// latency and hit policy, plus a per-step reference model of the motion rules.
`timescale 1ns/1ps
module tb_pacman_motion_ctrl;

   localparam int FRAME_CYC = 40;
   localparam int VS_LO     = 6;
   localparam int HIT_NONE  = 0;
   localparam int HIT_ALL   = 1;
   localparam int HIT_VERT  = 2;
   localparam int HIT_RAND  = 3;

   logic       vga_clk  = 1'b0;
   logic       reset    = 1'b1;
   logic       vs_n     = 1'b1;
   logic [7:0] key_code = 8'h00;
   logic       resp_ack = 1'b0;
   logic       late_ack = 1'b0;
   logic       wall_hit = 1'b0;
   logic       wall_ack;
   logic       wall_req;
   logic [9:0] cand_x;
   logic [8:0] cand_y;
   logic [9:0] sprite_x;
   logic [8:0] sprite_y;
   logic [1:0] dir;
   logic       moving;
   logic       step_done;

   assign wall_ack = resp_ack | late_ack;

   int checks   = 0;
   int errors   = 0;
   int hit_mode = HIT_NONE;
   int ack_lat  = 0;
   int sd_count = 0;
   bit stalled  = 0;

   typedef struct {
      int x;
      int y;
      bit hit;
   } req_t;
   req_t req_log[$];

   // reference model state
   int mx   = 304;
   int my   = 224;
   int mdir = 2;
   bit mqv  = 0;
   int mqd  = 0;

   pacman_motion_ctrl #(.STEP_FRAMES(2)) dut (
      .vga_clk  (vga_clk),
      .reset    (reset),
      .vs_n     (vs_n),
      .key_code (key_code),
      .wall_ack (wall_ack),
      .wall_hit (wall_hit),
      .wall_req (wall_req),
      .cand_x   (cand_x),
      .cand_y   (cand_y),
      .sprite_x (sprite_x),
      .sprite_y (sprite_y),
      .dir      (dir),
      .moving   (moving),
      .step_done(step_done)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // vertical sync: short active-low pulse each frame
   initial forever begin
      repeat (FRAME_CYC - VS_LO) @(posedge vga_clk);
      #1 vs_n = 1'b0;
      repeat (VS_LO) @(posedge vga_clk);
      #1 vs_n = 1'b1;
   end

   // wall lookup responder
   initial forever begin
      @(posedge vga_clk);
      #1;
      if (wall_req === 1'b1 && !reset) begin
         int cx, cy, waited;
         bit moved, aborted, h;
         cx = int'(cand_x); cy = int'(cand_y);
         moved = 0; aborted = 0; waited = 0;
         while (waited < ack_lat && !aborted) begin
            @(posedge vga_clk);
            #1;
            waited++;
            if (reset) aborted = 1;
            else if (int'(cand_x) != cx || int'(cand_y) != cy || wall_req !== 1'b1) moved = 1;
         end
         if (!aborted) begin
            case (hit_mode)
               HIT_NONE: h = 0;
               HIT_ALL:  h = 1;
               HIT_VERT: h = (cy != int'(sprite_y));
               default:  h = ($urandom_range(0, 2) == 0);
            endcase
            resp_ack = 1'b1;
            wall_hit = h;
            req_log.push_back('{cx, cy, h});
            @(posedge vga_clk);
            #1;
            resp_ack = 1'b0;
            wall_hit = 1'b0;
            check("req_stable", moved, 0);
            check("req_drop", wall_req, 0);
         end
      end
   end

   // step pulse counter, commit-in-vsync and position-change checks
   logic       prev_vs = 1'b1;
   logic [9:0] px;
   logic [8:0] py;
   always @(negedge vga_clk) begin
      if (!reset) begin
         if (step_done === 1'b1) begin
            sd_count++;
            if (moving === 1'b1) check("commit_in_vs", prev_vs, 0);
         end
         if (sprite_x !== px || sprite_y !== py) check("pos_needs_step", step_done, 1);
      end
      prev_vs = vs_n;
      px      = sprite_x;
      py      = sprite_y;
   end

   function automatic bit key_dir(input logic [7:0] k, output int d);
      d = 0;
      case (k)
         8'h74: d = 0;
         8'h75: d = 1;
         8'h6B: d = 2;
         8'h72: d = 3;
         default: return 0;
      endcase
      return 1;
   endfunction

   task automatic try_move(input int d, output bit ok, output int nx, output int ny);
      bit edge_blk;
      edge_blk = 0;
      nx = mx;
      ny = my;
      ok = 0;
      case (d)
         0: nx = (mx + 2 > 608) ? 0 : mx + 2;
         2: nx = (mx < 2) ? 608 : mx - 2;
         1: if (my < 2) edge_blk = 1; else ny = my - 2;
         default: if (my + 2 > 448) edge_blk = 1; else ny = my + 2;
      endcase
      if (!edge_blk) begin
         if (req_log.size() == 0) begin
            check("req_count", req_log.size(), 1);
         end else begin
            req_t r;
            r = req_log.pop_front();
            check("cand_x", r.x, nx);
            check("cand_y", r.y, ny);
            ok = !r.hit;
         end
      end
   endtask

   task automatic model_step();
      int kd, nx, ny;
      bit ok, moved;
      moved = 0;
      if (key_dir(key_code, kd)) begin mqv = 1; mqd = kd; end
      if (mqv && mqd != mdir) begin
         try_move(mqd, ok, nx, ny);
         if (ok) begin mdir = mqd; mqv = 0; moved = 1; end
      end
      if (!moved) try_move(mdir, moved, nx, ny);
      if (moved) begin mx = nx; my = ny; end
      if (key_dir(key_code, kd)) begin mqv = 1; mqd = kd; end
      check("extra_req", req_log.size(), 0);
      req_log.delete();
      check("sprite_x", sprite_x, mx);
      check("sprite_y", sprite_y, my);
      check("dir", dir, mdir);
      check("moving", moving, moved);
   endtask

   task automatic wait_step(output bit ok);
      int n;
      n  = 0;
      ok = 0;
      while (n < 3000 && !ok) begin
         @(negedge vga_clk);
         if (step_done === 1'b1) ok = 1;
         n++;
      end
      check("step_seen", ok, 1);
      if (!ok) stalled = 1;
   endtask

   task automatic run_step();
      bit ok;
      if (!stalled) begin
         wait_step(ok);
         if (ok) begin
            model_step();
            @(negedge vga_clk);
            check("step_pulse", step_done, 0);
         end
      end
   endtask

   initial begin
      int guard, c0, c1;
      logic [7:0] keys [6];
      keys[0] = 8'h74; keys[1] = 8'h75; keys[2] = 8'h6B;
      keys[3] = 8'h72; keys[4] = 8'h00; keys[5] = 8'hF0;

      repeat (3) @(posedge vga_clk);
      #1;
      check("rst_x", sprite_x, 304);
      check("rst_y", sprite_y, 224);
      check("rst_dir", dir, 2);
      check("rst_moving", moving, 0);
      check("rst_req", wall_req, 0);
      check("rst_cand_x", cand_x, 0);
      check("rst_cand_y", cand_y, 0);
      check("rst_step", step_done, 0);
      reset = 1'b0;

      // straight left, every lookup free
      for (int k = 1; k <= 5; k++) begin
         run_step();
         check("t1_x", sprite_x, 304 - 2 * k);
      end

      // run left to the tunnel, then reverse across both wraps
      guard = 0;
      while (mx != 0 && !stalled && guard < 400) begin run_step(); guard++; end
      run_step();
      check("t2_left_wrap", sprite_x, 608);
      key_code = 8'h74;
      run_step();
      check("t2_right_wrap", sprite_x, 0);
      check("t2_dir_right", dir, 0);
      key_code = 8'h6B;
      run_step();
      check("t2_left_tunnel", sprite_x, 608);

      // queued up is walled: keep heading left
      key_code = 8'h75;
      hit_mode = HIT_VERT;
      run_step();
      run_step();
      check("t3_x", sprite_x, 604);
      check("t3_dir", dir, 2);

      // everything walled: hold position
      hit_mode = HIT_ALL;
      run_step();
      check("t4_hold_moving", moving, 0);
      check("t4_hold_x", sprite_x, 604);
      hit_mode = HIT_NONE;
      guard = 0;
      while (my != 0 && !stalled && guard < 400) begin run_step(); guard++; end
      run_step();
      check("t4_top_y", sprite_y, 0);
      check("t4_top_moving", moving, 0);

      // long ack latency: overlapping tick dropped, exactly one step
      key_code = 8'h6B;
      ack_lat  = 100;
      @(posedge vga_clk);
      #1;
      c0 = sd_count;
      run_step();
      @(posedge vga_clk);
      #1;
      c1 = sd_count;
      check("t5_one_step", c1, c0 + 1);
      repeat (25) @(posedge vga_clk);
      #1;
      check("t5_no_extra", sd_count, c1);
      ack_lat = 0;

      // randomized steps
      for (int i = 0; i < 150 && !stalled; i++) begin
         key_code = keys[$urandom_range(0, 5)];
         hit_mode = $urandom_range(0, 3);
         ack_lat  = ($urandom_range(0, 9) == 0) ? 60 : $urandom_range(0, 3);
         run_step();
      end

      // reset in the middle of a pending lookup
      hit_mode = HIT_NONE;
      ack_lat  = 1000;
      key_code = 8'h74;
      guard    = 0;
      while (wall_req !== 1'b1 && guard < 3000) begin @(negedge vga_clk); guard++; end
      check("t6_req_seen", wall_req, 1);
      repeat (10) @(negedge vga_clk);
      #2 reset = 1'b1;
      #1;
      check("t6_req", wall_req, 0);
      check("t6_x", sprite_x, 304);
      check("t6_y", sprite_y, 224);
      check("t6_dir", dir, 2);
      check("t6_moving", moving, 0);
      check("t6_step", step_done, 0);
      check("t6_cand_x", cand_x, 0);
      check("t6_cand_y", cand_y, 0);
      key_code = 8'h00;
      repeat (3) @(posedge vga_clk);
      #1 reset = 1'b0;
      ack_lat = 0;
      mx = 304; my = 224; mdir = 2; mqv = 0; mqd = 0;
      req_log.delete();
      c0 = sd_count;
      late_ack = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge vga_clk);
         #1;
         check("t6_late_req", wall_req, 0);
      end
      late_ack = 1'b0;
      check("t6_late_step", sd_count, c0);
      check("t6_late_x", sprite_x, 304);
      run_step();
      run_step();
      check("t6_after_x", sprite_x, 300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
